// File: rtl/mul_wb_buffer_pkg.sv
// Shared types for the multiply writeback buffer: result-uop and branch-bus layouts,
// sequence-number width and the speculative-kill test.
package mul_wb_buffer_pkg;

    localparam int SQN_W    = 7;
    localparam int UOP_W    = 88;
    localparam int BRANCH_W = 76;

    localparam int UOP_VALID_BIT  = 0;
    localparam int UOP_COMPR_BIT  = 1;
    localparam int UOP_FLAGS_LSB  = 2;
    localparam int UOP_PC_LSB     = 5;
    localparam int UOP_SQN_LSB    = 37;
    localparam int UOP_NMDST_LSB  = 44;
    localparam int UOP_TAGDST_LSB = 49;
    localparam int UOP_RESULT_LSB = 56;

    typedef struct packed {
        logic [31:0]      result;
        logic [6:0]       tagDst;
        logic [4:0]       nmDst;
        logic [SQN_W-1:0] sqN;
        logic [31:0]      pc;
        logic [2:0]       flags;
        logic             compressed;
        logic             valid;
    } res_uop_t;

    typedef struct packed {
        logic [31:0]      rsvHi;
        logic [SQN_W-1:0] sqN;
        logic [35:0]      rsvLo;
        logic             taken;
    } branch_t;

    // An op is killed when it is strictly younger (modulo sqN wrap) than a mispredicted branch.
    function automatic logic killed(input logic [SQN_W-1:0] sqn, input branch_t br);
        logic [SQN_W-1:0] diff;
        diff = sqn - br.sqN;
        return br.taken && !diff[SQN_W-1] && (diff != '0);
    endfunction

endpackage

// File: rtl/mul_wb_buffer_ram.sv
// Result storage for the multiply writeback buffer: one synchronous write port and
// one asynchronous read port.
module res_fifo_ram
    import mul_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we_i,
    input  logic [AW-1:0]  waddr_i,
    input  res_uop_t       wdata_i,
    input  logic [AW-1:0]  raddr_i,
    output res_uop_t       rdata_o
);

    res_uop_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mul_wb_buffer.sv
// Multiply result buffer between the multiplier and the writeback arbiter, with branch flush.
// Optional same-cycle bypass of an empty buffer is enabled by defining MUL_WB_BYPASS_EN.
module mul_wb_buffer
    import mul_wb_buffer_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int INFLIGHT = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BRANCH_W-1:0] IN_branch,
    input  logic [UOP_W-1:0]    IN_uop,
    input  logic                IN_wbGrant,
    output logic [UOP_W-1:0]    OUT_uop,
    output logic                OUT_stall,
    output logic                OUT_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    branch_t  br;
    res_uop_t inUop;
    res_uop_t headUop;
    res_uop_t outUop;

    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             stall_q, stall_d;
    logic             ovf_q, ovf_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [SQN_W-1:0] sqn_q [DEPTH];

    logic empty, full;
    logic inValid;
    logic headLive, headValid;
    logic pop, push, drop;
    logic bypassTake;
    logic unusedBranchBits;

    assign br    = branch_t'(IN_branch);
    assign inUop = res_uop_t'(IN_uop);
    assign unusedBranchBits = ^{br.rsvHi, br.rsvLo};

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign inValid   = inUop.valid && !killed(inUop.sqN, br);
    assign headLive  = vld_q[rdPtr_q];
    assign headValid = headLive && !killed(sqn_q[rdPtr_q], br) && !empty;

`ifdef MUL_WB_BYPASS_EN
    logic bypassHit;
    assign bypassHit  = empty && inValid;
    assign bypassTake = bypassHit && IN_wbGrant;

    always_comb begin
        outUop       = headUop;
        outUop.valid = headValid;
        if (bypassHit) begin
            outUop = inUop;
        end
    end
`else
    assign bypassTake = 1'b0;

    always_comb begin
        outUop       = headUop;
        outUop.valid = headValid;
    end
`endif

    assign OUT_uop      = outUop;
    assign OUT_stall    = stall_q;
    assign OUT_overflow = ovf_q;

    // Flushed entries stay in place as holes and drain one per cycle from the head.
    assign pop  = !empty && ((IN_wbGrant && headValid) || !headLive);
    assign push = inValid && (!full || pop) && !bypassTake;
    assign drop = inValid && full && !pop;

    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (killed(sqn_q[i], br)) begin
                vld_d[i] = 1'b0;
            end
        end
        if (pop) begin
            vld_d[rdPtr_q] = 1'b0;
        end
        if (push) begin
            vld_d[wrPtr_q] = 1'b1;
        end

        wrPtr_d = push ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        stall_d = (DEPTH - int'(count_d)) <= INFLIGHT;
        ovf_d   = ovf_q || drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sqn_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
            if (push) begin
                sqn_q[wrPtr_q] <= inUop.sqN;
            end
        end
    end

    res_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wrPtr_q),
        .wdata_i (inUop),
        .raddr_i (rdPtr_q),
        .rdata_o (headUop)
    );

endmodule

// File: tb/tb_mul_wb_buffer.sv
// Scoreboard bench for mul_wb_buffer; expectations adapt when MUL_WB_BYPASS_EN is defined.
module tb_mul_wb_buffer;
    import mul_wb_buffer_pkg::*;

`ifdef MUL_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [75:0] IN_branch;
    logic [87:0] IN_uop;
    logic        IN_wbGrant;
    logic [87:0] OUT_uop;
    logic        OUT_stall;
    logic        OUT_overflow;

    int checks = 0;
    int passes = 0;
    logic [87:0] expQ [$];

    always #5 clk = ~clk;

    mul_wb_buffer #(
        .DEPTH    (8),
        .INFLIGHT (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_branch    (IN_branch),
        .IN_uop       (IN_uop),
        .IN_wbGrant   (IN_wbGrant),
        .OUT_uop      (OUT_uop),
        .OUT_stall    (OUT_stall),
        .OUT_overflow (OUT_overflow)
    );

    function automatic logic [87:0] makeUop(input logic [6:0] sqn, input logic [31:0] res);
        res_uop_t u;
        u.valid      = 1'b1;
        u.compressed = sqn[0];
        u.flags      = sqn[2:0];
        u.pc         = 32'h0000_1000 + {23'd0, sqn, 2'b00};
        u.sqN        = sqn;
        u.nmDst      = sqn[4:0];
        u.tagDst     = sqn;
        u.result     = res;
        return u;
    endfunction

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [6:0] sqn, input logic grant,
                                 input logic brTaken, input logic [6:0] brSqn,
                                 input logic expectOut);
        IN_uop        = v ? makeUop(sqn, 32'hA5A5_0000 | {25'd0, sqn}) : '0;
        IN_wbGrant    = grant;
        IN_branch     = '0;
        IN_branch[0]  = brTaken;
        IN_branch[43:37] = brSqn;
        if (v && expectOut) begin
            expQ.push_back(makeUop(sqn, 32'hA5A5_0000 | {25'd0, sqn}));
        end
    endtask

    task automatic idle(input logic grant);
        applyStimulus(1'b0, 7'd0, grant, 1'b0, 7'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted writeback must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && OUT_uop[0] && IN_wbGrant) begin
                checks++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL wb unexpected: got %0h expected nothing at %0t", OUT_uop, $time);
                end else begin
                    logic [87:0] exp;
                    exp = expQ.pop_front();
                    if (OUT_uop === exp) begin
                        passes++;
                    end else begin
                        $display("[TB] FAIL wb result: got %0h expected %0h at %0t", OUT_uop, exp, $time);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        checks++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        rst        = 1'b1;
        IN_uop     = '0;
        IN_branch  = '0;
        IN_wbGrant = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out valid", OUT_uop[0], 1'b0);
        checkOutput("reset stall", OUT_stall, 1'b0);
        checkOutput("reset overflow", OUT_overflow, 1'b0);
        rst = 1'b0;

        $display("[TB] streaming sqN 3,5,7 with grant");
        applyStimulus(1'b1, 7'd3, 1'b1, 1'b0, 7'd0, 1'b1);
        #1 checkOutput("stream t0 valid", OUT_uop[0], BYP);
        step();
        applyStimulus(1'b1, 7'd5, 1'b1, 1'b0, 7'd0, 1'b1);
        #1 checkOutput("stream t1 valid", OUT_uop[0], 1'b1);
        step();
        applyStimulus(1'b1, 7'd7, 1'b1, 1'b0, 7'd0, 1'b1);
        #1 checkOutput("stream t2 valid", OUT_uop[0], 1'b1);
        step();
        idle(1'b1);
        #1 checkOutput("stream t3 valid", OUT_uop[0], !BYP);
        step();
        idle(1'b0);
        #1 checkOutput("stream drained", OUT_uop[0], 1'b0);
        step();

        $display("[TB] flush of younger entries");
        applyStimulus(1'b1, 7'd10, 1'b0, 1'b0, 7'd0, 1'b1);
        step();
        applyStimulus(1'b1, 7'd12, 1'b0, 1'b0, 7'd0, 1'b0);
        step();
        applyStimulus(1'b1, 7'd14, 1'b0, 1'b0, 7'd0, 1'b0);
        step();
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b1, 7'd11, 1'b0);
        #1 checkOutput("older head survives flush", OUT_uop[0], 1'b1);
        step();
        idle(1'b1);
        #1 checkOutput("sqN 10 offered", OUT_uop[0], 1'b1);
        step();
        idle(1'b0);
        #1 checkOutput("hole 1 not offered", OUT_uop[0], 1'b0);
        step();
        idle(1'b0);
        #1 checkOutput("hole 2 not offered", OUT_uop[0], 1'b0);
        step();
        applyStimulus(1'b1, 7'd21, 1'b0, 1'b0, 7'd0, 1'b1);
        #1 checkOutput("empty after holes", OUT_uop[0], BYP);
        step();
        idle(1'b1);
        #1 checkOutput("new push at head", OUT_uop[0], 1'b1);
        step();
        idle(1'b0);
        step();

        $display("[TB] fill to full, stall and overflow");
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 7'(39 + k), 1'b0, 1'b0, 7'd0, 1'b1);
            step();
            checkOutput($sformatf("stall after %0d pushes", k), OUT_stall, (8 - k) <= 5);
        end
        checkOutput("full no overflow", OUT_overflow, 1'b0);
        applyStimulus(1'b1, 7'd48, 1'b1, 1'b0, 7'd0, 1'b1);
        #1 checkOutput("full head valid", OUT_uop[0], 1'b1);
        step();
        checkOutput("push+pop when full overflow", OUT_overflow, 1'b0);
        checkOutput("push+pop when full stall", OUT_stall, 1'b1);
        applyStimulus(1'b1, 7'd49, 1'b0, 1'b0, 7'd0, 1'b0);
        step();
        checkOutput("drop sets overflow", OUT_overflow, 1'b1);
        for (int k = 0; k < 8; k++) begin
            idle(1'b1);
            step();
        end
        idle(1'b0);
        #1;
        checkOutput("drained out valid", OUT_uop[0], 1'b0);
        checkOutput("drained stall", OUT_stall, 1'b0);
        checkOutput("overflow sticky", OUT_overflow, 1'b1);

        $display("[TB] reset with buffered entries");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 7'(60 + k), 1'b0, 1'b0, 7'd0, 1'b0);
            step();
        end
        checkOutput("four entries stall", OUT_stall, 1'b1);
        idle(1'b0);
        #1 rst = 1'b1;
        #1;
        checkOutput("async reset out valid", OUT_uop[0], 1'b0);
        checkOutput("async reset stall", OUT_stall, 1'b0);
        checkOutput("async reset overflow", OUT_overflow, 1'b0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("post reset out valid", OUT_uop[0], 1'b0);
        checkOutput("post reset stall", OUT_stall, 1'b0);
        applyStimulus(1'b1, 7'd70, 1'b0, 1'b0, 7'd0, 1'b1);
        step();
        idle(1'b1);
        #1 checkOutput("first push after reset", OUT_uop[0], 1'b1);
        step();
        idle(1'b0);
        step();
        checkOutput("scoreboard drained", expQ.size() == 0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mul_wb_buffer.md
MUL_WB_BUFFER -- requirements
Module: mul_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 8: number of result-buffer entries; power of two, 4 to 16.
REQ-002 Parameter INFLIGHT, default 5: maximum number of multiply results that can still arrive after OUT_stall asserts.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 IN_branch  in  76  branch bus; [0] = mispredict taken, [43:37] = branch sqN.
REQ-006 IN_uop  in  88  multiply result; [0] valid, [1] compressed, [4:2] flags, [36:5] pc, [43:37] sqN, [48:44] nmDst, [55:49] tagDst, [87:56] result.
REQ-007 IN_wbGrant  in  1  writeback arbiter accepts OUT_uop this cycle.
REQ-008 OUT_uop  out  88  head result, same layout as IN_uop.
REQ-009 OUT_stall  out  1  issue stage SHALL stop issuing multiplies.
REQ-010 OUT_overflow  out  1  sticky error: a result was dropped.

Function
REQ-011 The block SHALL define "killed(sqN)" as IN_branch[0] && $signed(sqN - IN_branch[43:37]) > 0.
REQ-012 IN_uop SHALL be written at the tail when IN_uop[0] && !killed(IN_uop sqN) && not full; the write is visible at OUT_uop from the next cycle.
REQ-013 Each entry SHALL hold a valid bit; every cycle, entries with killed(entry sqN) SHALL have their valid bit cleared; pointers SHALL be unchanged by a flush.
REQ-014 OUT_uop SHALL present the head entry; OUT_uop[0] = head valid && !killed(head sqN) && count != 0.
REQ-015 Head SHALL pop when count != 0 and (IN_wbGrant && OUT_uop[0], or head valid bit clear); at most one pop per cycle.
REQ-016 Push and pop in the same cycle SHALL both occur; count is unchanged.
REQ-017 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-018 OUT_stall SHALL be registered and equal (DEPTH - count_next) <= INFLIGHT.
REQ-019 A push arriving while full and not popping SHALL be dropped, and OUT_overflow SHALL set and remain set until reset.
REQ-020 IN_wbGrant while OUT_uop[0]=0 SHALL have no effect, apart from a bubble pop under REQ-015.
REQ-021 OUT_uop fields other than [0] are don't-care while OUT_uop[0]=0.

Reset
REQ-022 On rst, all entry valid bits, pointers, count, OUT_stall and OUT_overflow SHALL clear to 0 asynchronously; OUT_uop[0] SHALL read 0.
REQ-023 Reset mid-operation SHALL discard all buffered results; the first push after deassertion is accepted normally.

Configuration
REQ-024 With MUL_WB_BYPASS_EN defined: when count = 0 and IN_uop is valid and not killed, OUT_uop SHALL equal IN_uop combinationally in the same cycle.
- If IN_wbGrant is also high that cycle, the result SHALL NOT be written into the buffer.
- Otherwise it SHALL be pushed as in REQ-012.
REQ-025 Without MUL_WB_BYPASS_EN: minimum latency from input to output SHALL be exactly 1 cycle, with no combinational path from IN_uop to OUT_uop.

Structure
REQ-026 The shared package SHALL hold:
- the 88-bit result-uop typedef and its field offsets;
- the branch-bus typedef;
- the sqN width constant (7);
- the function implementing killed().
REQ-027 One sub-module, res_fifo_ram (DEPTH x 88 storage, write/read ports), is natural; control SHALL live in mul_wb_buffer.

Verification
REQ-028 Push sqN=3,5,7 on consecutive cycles with IN_wbGrant=1 -> OUT_uop valid with sqN 3,5,7 on cycles t+1..t+3 (no bypass).
REQ-029 Fill 3 entries (sqN 10,12,14), IN_wbGrant=0, branch taken with sqN=11 -> sqN 12 and 14 invalidated; sqN 10 is output on grant; the two holes pop in 2 idle cycles; count reaches 0.
REQ-030 DEPTH=8, INFLIGHT=5, hold grant low -> OUT_stall rises the cycle after count reaches 3; 9th push is dropped and OUT_overflow=1.
REQ-031 Full buffer, simultaneous push and grant -> push accepted, count stays 8, OUT_overflow stays 0.
REQ-032 rst asserted mid-cycle with 4 entries -> OUT_uop[0]=0 immediately; after release count=0 and OUT_stall=0.
REQ-033 MUL_WB_BYPASS_EN, empty buffer, IN_uop sqN=20 with grant=1 -> OUT_uop sqN=20 in the same cycle and count stays 0; same stimulus without the macro -> output appears next cycle.
